// File: rtl/exp_horner_sequencer_if.sv
// Command/handshake bundle between the range-reduction front end, the
// Horner sequencer and the shared multiplier/adder datapath.
interface exp_horner_sequencer_if #(
    parameter int CNT_W = 3
);
    logic             start;
    logic             abort;
    logic             stall;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] coef_addr;
    logic             acc_ld;
    logic             mul_ss;
    logic             mul_ss_en;
    logic             add_ss;
    logic             add_ss_en;

    // Sequencer side
    modport slave (
        input  start, abort, stall,
        output busy, done, coef_addr, acc_ld, mul_ss, mul_ss_en, add_ss, add_ss_en
    );

    // Front end / datapath side
    modport master (
        output start, abort, stall,
        input  busy, done, coef_addr, acc_ld, mul_ss, mul_ss_en, add_ss, add_ss_en
    );
endinterface

// File: rtl/exp_horner_sequencer.sv
// Horner-form polynomial sequencer for the exponential unit's Taylor datapath.
// Issues one load/multiply/add command per cycle and walks the coefficient
// ROM address from N_TERMS down to 0. Drives selects and enables only.
//
// state | meaning
// IDLE  | waiting for start, all outputs low
// LOAD  | accumulator loads c[N_TERMS]
// MUL   | multiplier computes acc*x
// ADD   | accumulator takes mul_out + c[k]
// DONE  | accumulator holds y, done pulses
module exp_horner_sequencer #(
    parameter int N_TERMS = 4,
    parameter int CNT_W   = 3
) (
    input logic                  CLK,
    input logic                  rst,
    exp_horner_sequencer_if.slave bus
);

    if (N_TERMS < 1 || (1 << CNT_W) <= N_TERMS) begin : g_bad_params
        $error("exp_horner_sequencer: need N_TERMS >= 1 and 2**CNT_W > N_TERMS");
    end

    localparam logic [CNT_W-1:0] K_TOP    = CNT_W'(N_TERMS);
    localparam logic [CNT_W-1:0] K_TOP_M1 = CNT_W'(N_TERMS - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        MUL  = 3'd2,
        ADD  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] k_q, k_d;

    // State and term counter registers
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
        end
    end

    // Next state: abort beats stall, stall freezes everything
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        if (bus.abort) begin
            state_d = IDLE;
            k_d     = '0;
        end else if (!bus.stall) begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_d = LOAD;
                        k_d     = K_TOP;
                    end
                end
                LOAD: begin
                    state_d = MUL;
                    k_d     = K_TOP_M1;
                end
                MUL: begin
                    state_d = ADD;
                end
                ADD: begin
                    // k==0 is tested before decrementing so k never wraps
                    if (k_q == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = MUL;
                        k_d     = k_q - 1'b1;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                    k_d     = '0;
                end
            endcase
        end
    end

    logic             busy_o, done_o, acc_ld_o, mul_ss_o, mul_en_o, add_ss_o, add_en_o;
    logic [CNT_W-1:0] addr_o;

    // Moore decode of state and k; stall only gates the three enables
    always_comb begin
        busy_o   = 1'b0;
        done_o   = 1'b0;
        acc_ld_o = 1'b0;
        mul_ss_o = 1'b0;
        mul_en_o = 1'b0;
        add_ss_o = 1'b0;
        add_en_o = 1'b0;
        addr_o   = '0;
        case (state_q)
            LOAD: begin
                busy_o   = 1'b1;
                acc_ld_o = 1'b1;
                addr_o   = K_TOP;
            end
            MUL: begin
                busy_o   = 1'b1;
                mul_ss_o = 1'b1;
                mul_en_o = 1'b1;
                addr_o   = k_q;
            end
            ADD: begin
                busy_o   = 1'b1;
                add_en_o = 1'b1;
                addr_o   = k_q;
            end
            DONE: begin
                busy_o   = 1'b1;
                done_o   = 1'b1;
                add_ss_o = 1'b1;
            end
            default: begin
                busy_o = 1'b0;
            end
        endcase
        if (bus.stall) begin
            acc_ld_o = 1'b0;
            mul_en_o = 1'b0;
            add_en_o = 1'b0;
        end
    end

    assign bus.busy      = busy_o;
    assign bus.done      = done_o;
    assign bus.coef_addr = addr_o;
    assign bus.acc_ld    = acc_ld_o;
    assign bus.mul_ss    = mul_ss_o;
    assign bus.mul_ss_en = mul_en_o;
    assign bus.add_ss    = add_ss_o;
    assign bus.add_ss_en = add_en_o;

endmodule

// File: tb/tb_exp_horner_sequencer.sv
// Bench for exp_horner_sequencer: N_TERMS=4 and N_TERMS=1 instances share
// stimulus; a position-in-evaluation model predicts every output each cycle.
module tb_exp_horner_sequencer;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    exp_horner_sequencer_if #(.CNT_W(3)) bus4 ();
    exp_horner_sequencer_if #(.CNT_W(1)) bus1 ();

    exp_horner_sequencer #(.N_TERMS(4), .CNT_W(3)) dut4 (.CLK(clk), .rst(rst), .bus(bus4));
    exp_horner_sequencer #(.N_TERMS(1), .CNT_W(1)) dut1 (.CLK(clk), .rst(rst), .bus(bus1));

    int vectors    = 0;
    int miscompares = 0;

    // Evaluation position: 0 idle, 1 load, 2..2N+1 mul/add pairs, 2N+2 done
    int p4 = 0;
    int p1 = 0;
    int cyc = 0;
    int done_at = -1;

    // Expected {busy,done,acc_ld,mul_ss,mul_ss_en,add_ss,add_ss_en,addr[3:0]}
    function automatic logic [10:0] exp_out(input int n, input int p, input bit st);
        logic [10:0] v;
        v = '0;
        if (p == 1) begin
            v[10] = 1'b1; v[8] = !st; v[3:0] = 4'(n);
        end else if (p >= 2 && p <= 2*n + 1) begin
            v[10] = 1'b1;
            v[3:0] = 4'(n - p/2);
            if (p % 2 == 0) begin
                v[7] = 1'b1; v[6] = !st;
            end else begin
                v[4] = !st;
            end
        end else if (p == 2*n + 2) begin
            v[10] = 1'b1; v[9] = 1'b1; v[5] = 1'b1;
        end
        return v;
    endfunction

    function automatic int next_p(input int n, input int p, input bit s, input bit a, input bit st);
        if (a) return 0;
        if (st) return p;
        if (p == 0) return s ? 1 : 0;
        if (p == 2*n + 2) return 0;
        return p + 1;
    endfunction

    task automatic check(input string tag, input logic [10:0] obs, input logic [10:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, expv);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic sample(input string tag, input bit st);
        check({tag, "_n4"}, {bus4.busy, bus4.done, bus4.acc_ld, bus4.mul_ss, bus4.mul_ss_en,
                             bus4.add_ss, bus4.add_ss_en, 1'b0, bus4.coef_addr}, exp_out(4, p4, st));
        check({tag, "_n1"}, {bus1.busy, bus1.done, bus1.acc_ld, bus1.mul_ss, bus1.mul_ss_en,
                             bus1.add_ss, bus1.add_ss_en, 3'b000, bus1.coef_addr}, exp_out(1, p1, st));
    endtask

    // One clock: drive at negedge, check before posedge, advance the model
    task automatic step(input string tag, input bit s, input bit a, input bit st);
        @(negedge clk);
        bus4.start = s; bus4.abort = a; bus4.stall = st;
        bus1.start = s; bus1.abort = a; bus1.stall = st;
        #1;
        sample(tag, st);
        if (bus4.done && !st && done_at < 0) done_at = cyc;
        @(posedge clk);
        p4 = next_p(4, p4, s, a, st);
        p1 = next_p(1, p1, s, a, st);
        cyc++;
    endtask

    task automatic restart_count();
        cyc = 0;
        done_at = -1;
    endtask

    initial begin
        rst = 1'b1;
        bus4.start = 0; bus4.abort = 0; bus4.stall = 0;
        bus1.start = 0; bus1.abort = 0; bus1.stall = 0;
        #12;
        sample("reset", 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Nominal: start in cycle 0, done expected in cycle 10
        restart_count();
        for (int i = 0; i < 13; i++) step("nominal", i == 0, 1'b0, 1'b0);
        check_int("nominal_done_cycle", done_at, 10);

        // Stall for 3 cycles over the second MUL (cycles 4..6)
        restart_count();
        for (int i = 0; i < 16; i++) step("stall", i == 0, 1'b0, i >= 4 && i <= 6);
        check_int("stall_done_cycle", done_at, 13);

        // Abort in cycle 5, restart in cycle 6
        restart_count();
        for (int i = 0; i < 6; i++) step("abort", i == 0, i == 5, 1'b0);
        check_int("abort_no_done", done_at, -1);
        restart_count();
        for (int i = 0; i < 12; i++) step("replay", i == 0, 1'b0, 1'b0);
        check_int("replay_done_cycle", done_at, 10);

        // Starts in cycles 3 and 10 ignored, cycle 11 starts a new run
        restart_count();
        for (int i = 0; i < 11; i++) step("ign_start", i == 0 || i == 3 || i == 10, 1'b0, 1'b0);
        check_int("ign_done_cycle", done_at, 10);
        restart_count();
        for (int i = 0; i < 12; i++) step("restart", i == 0, 1'b0, 1'b0);
        check_int("restart_done_cycle", done_at, 10);

        // Abort together with start in IDLE stays idle
        step("abort_start", 1'b1, 1'b1, 1'b0);
        step("abort_start", 1'b0, 1'b0, 1'b0);

        // Async reset mid-ADD (cycle 3 of N=4 run)
        restart_count();
        for (int i = 0; i < 3; i++) step("pre_rst", i == 0, 1'b0, 1'b0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        p4 = 0; p1 = 0;
        sample("async_rst", 1'b0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step("post_rst", 1'b0, 1'b0, 1'b0);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            step("random", ($urandom_range(3) == 0), ($urandom_range(24) == 0),
                 ($urandom_range(4) == 0));
        end
        for (int i = 0; i < 14; i++) step("drain", 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
